// File: rtl/hazard_sequencer.sv
// Hazard sequencer for the 5-stage MIPS core: RAW forwarding selects,
// load-use / branch-compare stalls, branch/jump flush of D, and a
// memory wait-state hold with a timeout that latches into an error halt.
module hazard_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rsD,
   input  logic [4:0]       rtD,
   input  logic [4:0]       rsE,
   input  logic [4:0]       rtE,
   input  logic [4:0]       writeregE,
   input  logic [4:0]       writeregM,
   input  logic [4:0]       writeregW,
   input  logic             regwriteE,
   input  logic             regwriteM,
   input  logic             regwriteW,
   input  logic             mem2regE,
   input  logic             mem2regM,
   input  logic             branchD,
   input  logic             jumpD,
   input  logic             pcsrcD,
   input  logic             mem_reqM,
   input  logic             mem_ready,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushW,
   output logic             forwardAD,
   output logic             forwardBD,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

   state_t          state;
   logic [WC_W-1:0] wait_cnt;
   logic            lwstall, brstall, hstall, mstall;

   // Hazard detection terms; the memory hold is combinational so a
   // zero-wait access never stalls and ready releases in the same cycle.
   always_comb begin
      lwstall = mem2regE & ((rtE == rsD) | (rtE == rtD));
      brstall = branchD &
                ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                 (mem2regM  & ((writeregM == rsD) | (writeregM == rtD))));
      hstall  = lwstall | brstall;
      mstall  = ((state != ERR) & mem_reqM & ~mem_ready) | (state == ERR);
   end

   // Forwarding selects and stall/flush controls, all forced low in reset.
   always_comb begin
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      forwardAD = 1'b0;
      forwardBD = 1'b0;
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      if (!reset) begin
         // M has priority over W: it holds the younger value.
         if (rsE != 5'd0 && rsE == writeregM && regwriteM)      forwardAE = 2'b10;
         else if (rsE != 5'd0 && rsE == writeregW && regwriteW) forwardAE = 2'b01;
         if (rtE != 5'd0 && rtE == writeregM && regwriteM)      forwardBE = 2'b10;
         else if (rtE != 5'd0 && rtE == writeregW && regwriteW) forwardBE = 2'b01;
         forwardAD = (rsD != 5'd0) & (rsD == writeregM) & regwriteM;
         forwardBD = (rtD != 5'd0) & (rtD == writeregM) & regwriteM;
         if (mstall) begin
            // Freeze the whole front end; only W takes a bubble so the
            // stalled M instruction is not retired twice.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else begin
            stallF = hstall;
            stallD = hstall;
            flushE = hstall;
            flushD = (pcsrcD | jumpD) & ~hstall;
         end
      end
   end

   // Memory wait-state FSM with timeout into an absorbing error state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_reqM & ~mem_ready) begin
                  state    <= WAIT;
                  wait_cnt <= WC_W'(1);
               end else begin
                  wait_cnt <= '0;
               end
            end
            WAIT: begin
               if (mem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
                  state   <= ERR;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ERR:     state <= ERR;
            default: state <= RUN;
         endcase
      end
   end

   // Saturating count of cycles in which fetch was held.
   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (stallF && stall_count != {CNT_W{1'b1}})
         stall_count <= stall_count + 1'b1;
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized + directed bench for hazard_sequencer against a behavioural model.
module tb_hazard_sequencer;

   localparam int TO    = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic regwriteE, regwriteM, regwriteW, mem2regE, mem2regM;
   logic branchD, jumpD, pcsrcD, mem_reqM, mem_ready;
   logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;
   logic forwardAD, forwardBD, mem_err;
   logic [1:0] forwardAE, forwardBE;
   logic [CNT_W-1:0] stall_count;

   int n_chk = 0;
   int n_err = 0;

   // model state: consecutive not-ready cycles of the current access, error halt, count
   int m_wait = 0;
   bit m_err  = 0;
   int m_cnt  = 0;

   hazard_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .mem2regE(mem2regE), .mem2regM(mem2regM),
      .branchD(branchD), .jumpD(jumpD), .pcsrcD(pcsrcD),
      .mem_reqM(mem_reqM), .mem_ready(mem_ready),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushW(flushW),
      .forwardAD(forwardAD), .forwardBD(forwardBD),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .mem_err(mem_err), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int fwd_e(input logic [4:0] src);
      if (src != 0 && src == writeregM && regwriteM) return 2;
      if (src != 0 && src == writeregW && regwriteW) return 1;
      return 0;
   endfunction

   task automatic clear_in();
      {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
      {regwriteE, regwriteM, regwriteW, mem2regE, mem2regM} = '0;
      {branchD, jumpD, pcsrcD, mem_reqM, mem_ready} = '0;
   endtask

   // Check all outputs for the current inputs, then clock once and advance the model.
   task automatic step();
      bit lw, br, h, ms;
      logic [6:0] vec;
      int ae, be;
      bit ad, bd;
      #1;
      lw = mem2regE && (rtE == rsD || rtE == rtD);
      br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                       (mem2regM && (writeregM == rsD || writeregM == rtD)));
      h  = lw || br;
      ms = m_err || (mem_reqM && !mem_ready);
      ae = fwd_e(rsE);
      be = fwd_e(rtE);
      ad = (rsD != 0) && rsD == writeregM && regwriteM;
      bd = (rtD != 0) && rtD == writeregM && regwriteM;
      if (ms) vec = 7'b1111_001;
      else    vec = {h, h, 1'b0, 1'b0, (pcsrcD || jumpD) && !h, h, 1'b0};
      if (reset) begin
         vec = '0; ae = 0; be = 0; ad = 0; bd = 0;
      end
      chk("stall_flush", {stallF, stallD, stallE, stallM, flushD, flushE, flushW}, vec);
      chk("forwardAE", forwardAE, ae);
      chk("forwardBE", forwardBE, be);
      chk("forwardD", {forwardAD, forwardBD}, {ad, bd});
      chk("mem_err", mem_err, m_err);
      chk("stall_count", stall_count, m_cnt);
      @(posedge clk);
      if (reset) begin
         m_wait = 0; m_err = 0; m_cnt = 0;
      end else begin
         if (vec[6] && m_cnt < CMAX) m_cnt++;
         if (!m_err) begin
            if (m_wait == 0) begin
               if (mem_reqM && !mem_ready) m_wait = 1;
            end else if (mem_ready)  m_wait = 0;
            else if (m_wait == TO)   m_err = 1;
            else                     m_wait++;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      clear_in();
      reset = 1'b1;
      @(negedge clk);
      step();
      chk("rst_stallF", stallF, 0);
      step();
      reset = 1'b0;

      // forwarding priority M over W, and r0 never forwards
      rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
      #1 chk("t1_fwdAE_M", forwardAE, 2'b10);
      step();
      rsE = 0;
      #1 chk("t1_fwdAE_r0", forwardAE, 2'b00);
      step();

      // load-use: one bubble
      clear_in(); mem2regE = 1; rtE = 8; rsD = 8;
      #1 chk("t2_lwstall", {stallF, stallD, flushE}, 3'b111);
      step();
      clear_in();
      #1 chk("t2_cnt", stall_count, 1);
      step();

      // branch compare stalls then taken-branch flush
      branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3;
      step();
      regwriteE = 0; writeregE = 0; mem2regM = 1; writeregM = 3;
      step();
      clear_in(); branchD = 1; pcsrcD = 1;
      #1 chk("t3_flushD", flushD, 1);
      step();

      // three wait states then same-cycle release
      do_reset();
      mem_reqM = 1; mem_ready = 0;
      repeat (3) step();
      mem_ready = 1;
      #1 chk("t4_release", {stallF, stallM, flushW}, 3'b000);
      step();
      clear_in();
      #1 chk("t4_cnt", stall_count, 3);
      step();

      // timeout into error halt, stall_count saturation, reset recovery
      mem_reqM = 1; mem_ready = 0;
      repeat (8) step();
      #1 chk("t5_err", mem_err, 1);
      mem_reqM = 0; mem_ready = 1;
      #1 chk("t5_err_stall", {stallF, stallE, flushW}, 3'b111);
      repeat (12) step();
      #1 chk("t5_sat", stall_count, CMAX);
      do_reset();
      #1 chk("t5_rst", {mem_err, 4'(stall_count)}, 5'd0);
      step();

      // load-use under memory stall, then bubble, then reset mid-WAIT
      mem2regE = 1; rtE = 7; rsD = 7; mem_reqM = 1; mem_ready = 0;
      #1 chk("t6_mix", {flushE, stallE}, 2'b01);
      repeat (2) step();
      mem_ready = 1;
      #1 chk("t6_bubble", {flushE, stallE}, 2'b10);
      step();
      mem2regE = 0; mem_ready = 0;
      step();
      reset = 1'b1;
      #1 chk("t6_rst_out", {stallF, stallE, flushW}, 3'b000);
      step();
      reset = 1'b0; clear_in();
      step();

      // random traffic
      for (int i = 0; i < 500; i++) begin
         reset     = ($urandom_range(0, 99) < 2);
         rsD       = 5'($urandom_range(0, 3));
         rtD       = 5'($urandom_range(0, 3));
         rsE       = 5'($urandom_range(0, 3));
         rtE       = 5'($urandom_range(0, 3));
         writeregE = 5'($urandom_range(0, 3));
         writeregM = 5'($urandom_range(0, 3));
         writeregW = 5'($urandom_range(0, 3));
         {regwriteE, regwriteM, regwriteW} = 3'($urandom);
         mem2regE  = ($urandom_range(0, 3) == 0);
         mem2regM  = ($urandom_range(0, 3) == 0);
         branchD   = ($urandom_range(0, 3) == 0);
         jumpD     = ($urandom_range(0, 7) == 0);
         pcsrcD    = ($urandom_range(0, 3) == 0);
         mem_reqM  = ($urandom_range(0, 1) == 0);
         mem_ready = ($urandom_range(0, 9) < 5);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
